square_freq_meter: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 38 +++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/square_freq_meter.sv | 132 +++++++++++++
 tb/tb_square_freq_meter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the square-wave frequency meter: FSM state codes,
// measurement width, saturation value and result-encoding helpers.
package freq_meter_pkg;

    localparam int MEAS_W = 32;
    localparam logic [MEAS_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

    // Gate FSM state encoding.
    localparam logic [1:0] ST_ARM    = 2'd0;
    localparam logic [1:0] ST_GATE   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    // One latched measurement as seen on the output ports.
    typedef struct packed {
        logic [MEAS_W-1:0] count;
        logic [MEAS_W-1:0] code;
        logic              code_valid;
        logic              no_signal;
    } meas_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
        return (v == SAT_VAL) ? v : v + 1'b1;
    endfunction

    // Turns a raw edge count into the generator-compatible result bundle.
    function automatic meas_t encode_result(input logic [MEAS_W-1:0] count,
                                            input logic              no_sig,
                                            input logic [MEAS_W-1:0] code_max);
        meas_t r;
        r.count      = count;
        r.code       = (count == '0) ? '0 : count - 1'b1;
        r.code_valid = (count != '0) && (count <= code_max + 1'b1);
        r.no_signal  = no_sig;
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level input followed by a
// one-cycle rising-edge pulse. Reusable for push buttons and similar pins.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the input through the synchroniser and keep one extra delayed copy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, which is what makes this a shift chain.
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/square_freq_meter.sv
// Square-wave frequency meter: counts rising edges over a fixed gate window
// aligned to an arming edge, and tracks the period of the last input cycle.
module square_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50000000,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_CODE    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    output logic        meas_valid,
    output logic [31:0] freq_count,
    output logic [31:0] freq_code,
    output logic        code_valid,
    output logic [31:0] period_cyc,
    output logic        no_signal
);

    localparam logic [MEAS_W-1:0] GATE_LAST = MEAS_W'(GATE_CYCLES - 1);
    localparam logic [MEAS_W-1:0] CODE_MAX  = MEAS_W'(MAX_CODE);

    logic              rise;
    logic [1:0]        state_q,    state_d;
    logic [MEAS_W-1:0] timer_q,    timer_d;
    logic [MEAS_W-1:0] edge_cnt_q, edge_cnt_d;
    meas_t             result_q,   result_d;
    logic [MEAS_W-1:0] per_cnt_q,  per_cnt_d;
    logic [MEAS_W-1:0] period_q,   period_d;
    logic              seen_q,     seen_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(sig_in),
        .rise_o (rise)
    );

    // Gate FSM: wait for an arming edge, count edges for one window, report.
    always_comb begin
        // NOTE: every combinational output takes its hold value first, so no
        // path through the case statement can leave it unassigned (no latch).
        state_d    = state_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        result_d   = result_q;
        case (state_q)
            ST_ARM: begin
                if (rise) begin
                    // The arming edge only aligns the window; it is not counted.
                    timer_d    = '0;
                    edge_cnt_d = '0;
                    state_d    = ST_GATE;
                end else if (timer_q == GATE_LAST) begin
                    state_d  = ST_REPORT;
                    result_d = encode_result('0, 1'b1, CODE_MAX);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GATE: begin
                if (rise) begin
                    edge_cnt_d = sat_inc(edge_cnt_q);
                end
                // An edge in the final gate cycle still lands in this window.
                if (timer_q == GATE_LAST) begin
                    state_d  = ST_REPORT;
                    result_d = encode_result(edge_cnt_d, 1'b0, CODE_MAX);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REPORT: begin
                state_d = ST_ARM;
                timer_d = '0;
            end
            default: begin
                state_d = ST_ARM;
                timer_d = '0;
            end
        endcase
    end

    // Period tracker: free-running saturating counter captured on each edge.
    always_comb begin
        per_cnt_d = sat_inc(per_cnt_q);
        period_d  = period_q;
        seen_d    = seen_q;
        if (rise) begin
            per_cnt_d = '0;
            seen_d    = 1'b1;
            // The very first edge has no predecessor, so it only restarts the count.
            if (seen_q) begin
                period_d = sat_inc(per_cnt_q);
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        // NOTE: reset clears every register here because all of them are
        // visible or steer control; there is no storage array to leave alone.
        if (rst) begin
            state_q    <= ST_ARM;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            result_q   <= '0;
            per_cnt_q  <= '0;
            period_q   <= '0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            result_q   <= result_d;
            per_cnt_q  <= per_cnt_d;
            period_q   <= period_d;
            seen_q     <= seen_d;
        end
    end

    assign meas_valid = (state_q == ST_REPORT);
    assign freq_count = result_q.count;
    assign freq_code  = result_q.code;
    assign code_valid = result_q.code_valid;
    assign no_signal  = result_q.no_signal;
    assign period_cyc = period_q;

endmodule

// File: tb/tb_square_freq_meter.sv
// Self-checking bench for square_freq_meter with a 1000-cycle gate window.
module tb_square_freq_meter;

    localparam int GATE = 1000;
    localparam int MAXC = 9;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic        meas_valid;
    logic [31:0] freq_count;
    logic [31:0] freq_code;
    logic        code_valid;
    logic [31:0] period_cyc;
    logic        no_signal;

    int total = 0;
    int bad   = 0;
    longint cyc = 0;

    // Square-wave generator control: a request is applied only while the
    // wave is low, so a period change never produces a short glitch pulse.
    int req_period  = 0;
    int req_seq     = 0;
    int cur_period  = 0;
    int phase       = 0;
    int applied_seq = 0;

    typedef struct packed {
        logic [31:0] cnt;
        logic [31:0] code;
        logic        valid;
        logic        nosig;
        logic [31:0] per;
    } res_t;

    square_freq_meter #(
        .GATE_CYCLES(GATE),
        .SYNC_STAGES(2),
        .MAX_CODE   (MAXC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .meas_valid(meas_valid),
        .freq_count(freq_count),
        .freq_code (freq_code),
        .code_valid(code_valid),
        .period_cyc(period_cyc),
        .no_signal (no_signal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Wave generator: high for P/2 cycles, low for the rest, rising every P.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (req_seq != applied_seq && (cur_period == 0 || sig_in == 1'b0 || req_period == 0)) begin
                applied_seq = req_seq;
                cur_period  = req_period;
                phase       = cur_period / 2;
            end else if (cur_period != 0) begin
                phase = (phase + 1) % cur_period;
            end
            sig_in = (cur_period != 0) && (phase < cur_period / 2);
        end
    end

    // Reference model: in a window armed by one edge of a steady wave of
    // period p, the counted edges sit at p, 2p, ... up to the window length.
    function automatic res_t model(input int cnt, input int per);
        res_t r;
        r.cnt   = cnt;
        r.code  = (cnt == 0) ? 0 : cnt - 1;
        r.valid = (cnt >= 1) && (cnt <= MAXC + 1);
        r.nosig = (cnt == 0);
        r.per   = per;
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.cnt   = freq_count;
        r.code  = freq_code;
        r.valid = code_valid;
        r.nosig = no_signal;
        r.per   = period_cyc;
        return r;
    endfunction

    task automatic set_wave(input int p, input bit wait_applied);
        req_period = p;
        req_seq++;
        if (wait_applied) begin
            for (int i = 0; i < 2000 && applied_seq != req_seq; i++) @(posedge clk);
        end
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_meas(input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: meas_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        res_t o;
        set_wave(0, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = observed();
        total++;
        if ({o, meas_valid} !== '0) begin
            bad++;
            $display("FAIL reset_hold: got cnt=%0d code=%0d valid=%0b nosig=%0b per=%0d mv=%0b, want all 0",
                     o.cnt, o.code, o.valid, o.nosig, o.per, meas_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        o = observed();
        total++;
        if ({o, meas_valid} !== '0) begin
            bad++;
            $display("FAIL reset_release: got cnt=%0d per=%0d mv=%0b, want all 0", o.cnt, o.per, meas_valid);
        end
    endtask

    task automatic test_steady(input int p, input int exp_cnt, input string name);
        bit ok;
        res_t o, e;
        set_wave(0, 1'b1);
        pulse_reset(2);
        set_wave(p, 1'b1);
        wait_meas(2 * GATE + 2 * p + 50, name, ok);
        if (ok) begin
            o = observed();
            e = model(exp_cnt, p);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL %s p=%0d: got cnt=%0d code=%0d valid=%0b nosig=%0b per=%0d, want cnt=%0d code=%0d valid=%0b nosig=%0b per=%0d",
                         name, p, o.cnt, o.code, o.valid, o.nosig, o.per, e.cnt, e.code, e.valid, e.nosig, e.per);
            end
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int p;
            p = $urandom_range(600, 60);
            test_steady(p, GATE / p, "random_period");
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int p;
        longint t_prev, gap;
        res_t o, e;
        p = $urandom_range(300, 90);
        set_wave(0, 1'b1);
        pulse_reset(2);
        set_wave(p, 1'b1);
        wait_meas(2 * GATE + 2 * p + 50, "b2b_first", ok);
        t_prev = cyc;
        for (int k = 0; k < 2 && ok; k++) begin
            @(negedge clk);
            total++;
            if (meas_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_pulse_width: meas_valid=%0b one cycle after report, want 0", meas_valid);
            end
            wait_meas(GATE + 2 * p + 50, "b2b_next", ok);
            if (ok) begin
                gap = cyc - t_prev;
                t_prev = cyc;
                total++;
                if (gap < GATE + 2 || gap > GATE + 1 + p) begin
                    bad++;
                    $display("FAIL b2b_gap p=%0d: got %0d cycles between reports, want %0d..%0d", p, gap, GATE + 2, GATE + 1 + p);
                end
                o = observed();
                e = model(GATE / p, p);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL b2b_result p=%0d: got cnt=%0d code=%0d valid=%0b per=%0d, want cnt=%0d code=%0d valid=%0b per=%0d",
                             p, o.cnt, o.code, o.valid, o.per, e.cnt, e.code, e.valid, e.per);
                end
            end
        end
    endtask

    task automatic test_no_signal();
        bit ok;
        longint t_prev, gap;
        res_t o, e;
        set_wave(0, 1'b1);
        pulse_reset(2);
        e = model(0, 0);
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_meas(GATE + 20, "nosig_pulse", ok);
            if (!ok) break;
            o = observed();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL nosig_result: got cnt=%0d code=%0d valid=%0b nosig=%0b per=%0d, want cnt=0 code=0 valid=0 nosig=1 per=0",
                         o.cnt, o.code, o.valid, o.nosig, o.per);
            end
            if (k > 0) begin
                gap = cyc - t_prev;
                total++;
                if (gap != GATE + 1) begin
                    bad++;
                    $display("FAIL nosig_interval: got %0d cycles, want %0d", gap, GATE + 1);
                end
            end
            t_prev = cyc;
        end
    endtask

    task automatic test_reset_mid_gate();
        bit ok;
        bit spurious;
        res_t o, e;
        set_wave(0, 1'b1);
        pulse_reset(2);
        set_wave(100, 1'b1);
        wait_meas(2 * GATE + 300, "midrst_first", ok);
        if (!ok) return;
        repeat (550) @(negedge clk);
        pulse_reset(1);
        @(negedge clk);
        o = observed();
        total++;
        if ({o, meas_valid} !== '0) begin
            bad++;
            $display("FAIL midrst_clear: got cnt=%0d code=%0d per=%0d mv=%0b, want all 0", o.cnt, o.code, o.per, meas_valid);
        end
        spurious = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) spurious = 1'b1;
        end
        total++;
        if (spurious) begin
            bad++;
            $display("FAIL midrst_abandon: got meas_valid from abandoned window, want none");
        end
        wait_meas(2 * GATE + 300, "midrst_next", ok);
        if (ok) begin
            o = observed();
            e = model(10, 100);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL midrst_next: got cnt=%0d code=%0d valid=%0b per=%0d, want cnt=10 code=9 valid=1 per=100",
                         o.cnt, o.code, o.valid, o.per);
            end
        end
    endtask

    task automatic test_switch();
        bit ok;
        res_t o, e;
        set_wave(0, 1'b1);
        pulse_reset(2);
        set_wave(100, 1'b1);
        wait_meas(2 * GATE + 300, "switch_before", ok);
        if (!ok) return;
        o = observed();
        e = model(10, 100);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL switch_before: got cnt=%0d per=%0d, want cnt=10 per=100", o.cnt, o.per);
        end
        set_wave(250, 1'b0);
        e = model(4, 250);
        for (int k = 0; k < 2; k++) begin
            wait_meas(2 * GATE + 600, "switch_after", ok);
            if (!ok) break;
            o = observed();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL switch_after[%0d]: got cnt=%0d code=%0d valid=%0b per=%0d, want cnt=4 code=3 valid=1 per=250",
                         k, o.cnt, o.code, o.valid, o.per);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_steady(100, 10, "period_100");
        test_steady(80, 12, "period_80");
        test_steady(1000, 1, "period_1000");
        test_random(5);
        test_back_to_back();
        test_no_signal();
        test_reset_mid_gate();
        test_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
